// File: rtl/regwrite_checker_pkg.sv
// Shared types and constants for the register-write checker.
package regwrite_checker_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPass = 2'd1,
    StFail = 2'd2
  } state_e;

  localparam logic [1:0] FailNone      = 2'd0;
  localparam logic [1:0] FailMismatch  = 2'd1;
  localparam logic [1:0] FailOverflow  = 2'd2;
  localparam logic [1:0] FailEarlyHalt = 2'd3;

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  // {rd, data}
  localparam int unsigned EntryWidth = 37;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/regwrite_fifo.sv
// Synchronous FIFO holding observed commits; extra pointer bit distinguishes full from empty.
module regwrite_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + {{AddrW{1'b0}}, 1'b1};
      if (pop)  rptr_q <= rptr_q + {{AddrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AddrW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

endmodule

// File: rtl/regwrite_checker.sv
// Compares observed register-file commits against a stream of expected writes.
module regwrite_checker
  import regwrite_checker_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        commit_valid,
  input  logic [4:0]  commit_rd,
  input  logic [31:0] commit_data,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [4:0]  exp_rd,
  input  logic [31:0] exp_data,
  input  logic        exp_last,
  input  logic        halt,
  output logic [15:0] match_count,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] err_index
);

  state_e          state_q, state_d;
  logic [15:0]     match_q, match_d;
  logic [15:0]     err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            halt_q, halt_d;

  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;
  logic [EntryWidth-1:0] fifo_head;
  logic                  commit_live;

  assign commit_live = commit_valid && (commit_rd != 5'd0);
  assign fifo_pop    = exp_valid && exp_ready;
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign fifo_push   = (state_q == StRun) && commit_live && (!fifo_full || fifo_pop);

  regwrite_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({commit_rd, commit_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= StRun;
      match_q <= '0;
      err_q   <= '0;
      code_q  <= FailNone;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      err_q   <= err_d;
      code_q  <= code_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = err_q;
    code_d  = code_q;
    halt_d  = halt_q | halt;
    case (state_q)
      StRun: begin
        // Mismatch, overflow and early halt are mutually exclusive in practice,
        // but the ordering still encodes their priority.
        if (fifo_pop) begin
          if (fifo_head == {exp_rd, exp_data}) begin
            match_d = sat_inc16(match_q);
            if (exp_last) state_d = StPass;
          end else begin
            state_d = StFail;
            code_d  = FailMismatch;
            err_d   = match_q;
          end
        end else if (commit_live && fifo_full) begin
          state_d = StFail;
          code_d  = FailOverflow;
          err_d   = match_q;
        end else if (halt_q && fifo_empty) begin
          state_d = StFail;
          code_d  = FailEarlyHalt;
          err_d   = match_q;
        end
      end
      StPass: begin
        if (commit_live) begin
          state_d = StFail;
          code_d  = FailOverflow;
          err_d   = match_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    done      = (state_q != StRun);
    pass      = (state_q == StPass);
    exp_ready = (state_q == StRun) && !fifo_empty;
  end

  assign match_count = match_q;
  assign fail_code   = code_q;
  assign err_index   = err_q;

endmodule

// File: tb/tb_regwrite_checker.sv
// Random and directed stimulus against a queue-based reference of the checker rules.
module tb_regwrite_checker;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        commit_valid = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic        exp_last = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] match_count;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [15:0] err_index;

  regwrite_checker #(.FIFO_DEPTH(Depth)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .exp_valid    (exp_valid),
    .exp_ready    (exp_ready),
    .exp_rd       (exp_rd),
    .exp_data     (exp_data),
    .exp_last     (exp_last),
    .halt         (halt),
    .match_count  (match_count),
    .done         (done),
    .pass         (pass),
    .fail_code    (fail_code),
    .err_index    (err_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: 0 = running, 1 = passed, 2 = failed; queue of observed {rd, data}.
  int          m_state;
  int          m_match;
  int          m_code;
  int          m_err;
  bit          m_halt;
  logic [36:0] mq[$];

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_match = 0;
    m_code  = 0;
    m_err   = 0;
    m_halt  = 0;
  endtask

  task automatic m_fail(input int code);
    m_state = 2;
    m_code  = code;
    m_err   = m_match;
  endtask

  function automatic bit model_ready();
    return (m_state == 0) && (mq.size() != 0);
  endfunction

  function automatic logic [35:0] model_vec();
    logic [1:0]  c = m_code[1:0];
    logic [15:0] e = m_err[15:0];
    logic [15:0] m = m_match[15:0];
    return {m_state != 0, m_state == 1, c, e, m};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {done, pass, fail_code, err_index, match_count};
  endfunction

  task automatic model_step();
    bit          push;
    bit          hs;
    int          sz;
    logic [36:0] head;
    push = commit_valid && (commit_rd != 5'd0);
    hs   = exp_valid && model_ready();
    sz   = mq.size();
    if (m_state == 0) begin
      if (hs) begin
        head = mq.pop_front();
        if (head == {exp_rd, exp_data}) begin
          if (m_match < 65535) m_match++;
          if (exp_last) m_state = 1;
        end else m_fail(1);
      end else if (push && sz == Depth) m_fail(2);
      else if (m_halt && sz == 0) m_fail(3);
      if (push && (sz < Depth || hs)) mq.push_back({commit_rd, commit_data});
    end else if (m_state == 1 && push) m_fail(2);
    if (halt) m_halt = 1;
  endtask

  task automatic tick(input bit cv, input logic [4:0] rd, input logic [31:0] d,
                      input bit ev, input logic [36:0] e, input bit el, input bit h);
    @(negedge clk);
    commit_valid = cv;
    commit_rd    = rd;
    commit_data  = d;
    exp_valid    = ev;
    {exp_rd, exp_data} = e;
    exp_last     = el;
    halt         = h;
    #1;
    check_eq("exp_ready", exp_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    check_eq("outputs", dut_vec(), model_vec());
  endtask

  task automatic idle();
    tick(0, 5'd0, 32'd0, 0, 37'd0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    commit_valid = 0;
    exp_valid    = 0;
    exp_last     = 0;
    halt         = 0;
    #2;
    resetn = 1'b1;
    #1;
    check_eq("reset_outputs", dut_vec(), 36'd0);
    check_eq("reset_ready", exp_ready, 1'b0);
    model_reset();
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic pass_sequence();
    tick(1, 5'd1, 32'h5, 0, 37'd0, 0, 0);
    tick(1, 5'd2, 32'hA, 0, 37'd0, 0, 0);
    tick(0, 5'd0, 32'd0, 1, {5'd1, 32'h5}, 0, 0);
    tick(0, 5'd0, 32'd0, 1, {5'd2, 32'hA}, 1, 0);
    idle();
  endtask

  initial begin
    logic [36:0] e;
    bit          cv, ev, el, h;
    logic [4:0]  rd;

    model_reset();
    do_reset();

    // Two matching writes then the final record.
    pass_sequence();
    check_eq("pass_match_count", match_count, 16'd2);
    check_eq("pass_flags", {done, pass, fail_code}, 4'b1100);

    do_reset();
    tick(1, 5'd3, 32'h10, 0, 37'd0, 0, 0);
    tick(0, 5'd0, 32'd0, 1, {5'd3, 32'h11}, 0, 0);
    check_eq("mismatch_code", fail_code, 2'd1);
    check_eq("mismatch_err_index", err_index, 16'd0);
    check_eq("mismatch_flags", {done, pass}, 2'b10);

    do_reset();
    for (int i = 1; i <= 5; i++) tick(1, 5'(i), 32'(i * 3), 0, 37'd0, 0, 0);
    check_eq("overflow_code", fail_code, 2'd2);
    check_eq("overflow_done", done, 1'b1);

    do_reset();
    tick(1, 5'd0, 32'hDEAD, 0, 37'd0, 0, 0);
    tick(0, 5'd0, 32'd0, 0, 37'd0, 0, 1);
    idle();
    check_eq("early_halt_code", fail_code, 2'd3);
    check_eq("early_halt_match", match_count, 16'd0);

    do_reset();
    pass_sequence();
    tick(1, 5'd7, 32'h77, 0, 37'd0, 0, 0);
    check_eq("extra_write_code", fail_code, 2'd2);
    check_eq("extra_write_flags", {done, pass}, 2'b10);
    do_reset();

    // Buffered commits must not survive reset.
    tick(1, 5'd4, 32'h44, 0, 37'd0, 0, 0);
    tick(1, 5'd5, 32'h55, 0, 37'd0, 0, 0);
    do_reset();
    tick(0, 5'd0, 32'd0, 1, {5'd4, 32'h44}, 0, 0);
    tick(1, 5'd9, 32'h99, 0, 37'd0, 0, 0);
    tick(0, 5'd0, 32'd0, 1, {5'd9, 32'h99}, 1, 0);
    check_eq("post_reset_pass", {done, pass, match_count}, {2'b11, 16'd1});

    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 60 && m_state == 0; c++) begin
        cv = ($urandom_range(0, 9) < 4);
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ev = ($urandom_range(0, 9) < 6);
        if (mq.size() != 0) begin
          e = mq[0];
          if ($urandom_range(0, 24) == 0) e ^= (37'd1 << $urandom_range(0, 36));
        end else e = {5'($urandom), $urandom};
        el = ($urandom_range(0, 11) == 0);
        h  = ($urandom_range(0, 39) == 0);
        tick(cv, rd, $urandom, ev, e, el, h);
      end
      for (int c = 0; c < 3; c++)
        tick($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, 0, 37'd0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
